// File: rtl/wb_system_regs_pkg.sv
// Shared register map and ctrl layout for the Wishbone system-register block.
// Used by wb_system_regs and sysregs_event_counter.
package pkg_sysregs;

   localparam logic [7:0] SYSREGS_ADR_ID       = 8'h00;
   localparam logic [7:0] SYSREGS_ADR_FIFO     = 8'h01;
   localparam logic [7:0] SYSREGS_ADR_SCRATCH  = 8'h02;
   localparam logic [7:0] SYSREGS_ADR_UP_LO    = 8'h03;
   localparam logic [7:0] SYSREGS_ADR_UP_HI    = 8'h04;
   localparam logic [7:0] SYSREGS_ADR_CTRL     = 8'h05;
   localparam logic [7:0] SYSREGS_ADR_FLAGS    = 8'h06;
   localparam logic [7:0] SYSREGS_ADR_STATUS   = 8'h07;
   localparam logic [7:0] SYSREGS_ADR_CNT_BASE = 8'h08;

   localparam int CTRL_SRST_BIT   = 0;
   localparam int CTRL_LED_EN_BIT = 1;
   localparam int CTRL_LED_LSB    = 8;

   typedef struct packed {
      logic [15:0] led;
      logic [5:0]  rsvd;
      logic        led_en;
      logic        srst;
   } ctrl_t;

endpackage

// File: rtl/wb_system_regs_if.sv
// Wishbone classic slave bundle for the system-register slot.
// The master drives adr/dat_i/we/stb/cyc; the slave returns dat_o/ack.
interface wb_interface;

   logic [31:0] adr;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        we;
   logic        stb;
   logic        cyc;
   logic        ack;

   modport master (
      output adr, dat_i, we, stb, cyc,
      input  dat_o, ack
   );

   modport slave (
      input  adr, dat_i, we, stb, cyc,
      output dat_o, ack
   );

endinterface

// File: rtl/wb_system_regs_event_counter.sv
// Per-event edge detector with sticky W1C flag and saturating counter.
// A set beats a clear; a clear coinciding with an edge leaves the count at 1.
module sysregs_event_counter #(
   parameter int COUNTER_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     event_i,
   input  logic                     flag_clr,
   input  logic                     cnt_clr,
   output logic                     flag_o,
   output logic [COUNTER_WIDTH-1:0] cnt_o
);

   logic prev;
   logic rise;

   assign rise = event_i && !prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev   <= 1'b0;
         flag_o <= 1'b0;
         cnt_o  <= '0;
      end else begin
         prev <= event_i;
         if (rise)
            flag_o <= 1'b1;
         else if (flag_clr)
            flag_o <= 1'b0;
         if (cnt_clr)
            cnt_o <= COUNTER_WIDTH'(rise);
         else if (rise && cnt_o != '1)
            cnt_o <= cnt_o + 1'b1;
      end
   end

endmodule

// File: rtl/wb_system_regs.sv
// Wishbone system registers: ID, scratch, uptime, event flags/counters, soft reset, LEDs.
// Define SYSREGS_UPTIME_EN to build the 64-bit uptime counter and its shadow word.
module wb_system_regs
   import pkg_sysregs::*;
#(
   parameter logic [31:0] DESIGN_ID       = 32'h0000_0001,
   parameter int          WB_FIFO_DEPTH   = 2048,
   parameter int          NUM_EVENTS      = 4,
   parameter int          COUNTER_WIDTH   = 32,
   parameter int          SOFT_RST_CYCLES = 16,
   parameter int          LED_WIDTH       = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   wb_interface.slave            wb,
   input  logic [NUM_EVENTS-1:0] event_i,
   input  logic [31:0]           status_i,
   input  logic [LED_WIDTH-1:0]  led_i,
   output logic [LED_WIDTH-1:0]  led_o,
   output logic                  soft_rst_o
);

   localparam int SRST_W = $clog2(SOFT_RST_CYCLES + 1);

   logic [7:0]              a;
   logic                    acc;
   logic                    wr;
   logic                    rd;
   logic [31:0]             rdata;
   logic [31:0]             scratch;
   ctrl_t                   ctrl;
   logic [SRST_W-1:0]       srst_cnt;
   logic [NUM_EVENTS-1:0]   flags;
   logic [NUM_EVENTS-1:0]   flag_clr;
   logic [NUM_EVENTS-1:0]   cnt_clr;
   logic [COUNTER_WIDTH-1:0] cnt [NUM_EVENTS];
   logic                    unused_adr;

   assign a          = wb.adr[7:0];
   assign unused_adr = ^wb.adr[31:8];
   assign acc        = wb.cyc && wb.stb && !wb.ack;
   assign wr         = acc && wb.we;
   assign rd         = acc && !wb.we;

   assign led_o      = ctrl.led_en ? ctrl.led[LED_WIDTH-1:0] : led_i;
   assign soft_rst_o = (srst_cnt != '0);

   for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_ev
      assign flag_clr[k] = wr && a == SYSREGS_ADR_FLAGS && wb.dat_i[k];
      assign cnt_clr[k]  = wr && a == 8'(SYSREGS_ADR_CNT_BASE + k);

      sysregs_event_counter #(
         .COUNTER_WIDTH(COUNTER_WIDTH)
      ) u_ev (
         .clk      (clk),
         .rst_n    (rst_n),
         .event_i  (event_i[k]),
         .flag_clr (flag_clr[k]),
         .cnt_clr  (cnt_clr[k]),
         .flag_o   (flags[k]),
         .cnt_o    (cnt[k])
      );
   end

`ifdef SYSREGS_UPTIME_EN
   logic [63:0] uptime;
   logic [31:0] shadow;

   // High word is captured on the low-word read so the pair stays coherent.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         uptime <= '0;
         shadow <= '0;
      end else begin
         uptime <= uptime + 64'd1;
         if (rd && a == SYSREGS_ADR_UP_LO)
            shadow <= uptime[63:32];
      end
   end
`endif

   always_comb begin
      rdata = '0;
      unique case (a)
         SYSREGS_ADR_ID:      rdata = DESIGN_ID;
         SYSREGS_ADR_FIFO:    rdata = 32'(WB_FIFO_DEPTH);
         SYSREGS_ADR_SCRATCH: rdata = scratch;
`ifdef SYSREGS_UPTIME_EN
         SYSREGS_ADR_UP_LO:   rdata = uptime[31:0];
         SYSREGS_ADR_UP_HI:   rdata = shadow;
`endif
         SYSREGS_ADR_CTRL:    rdata = 32'(ctrl);
         SYSREGS_ADR_FLAGS:   rdata = 32'(flags);
         SYSREGS_ADR_STATUS:  rdata = status_i;
         default: begin
            for (int k = 0; k < NUM_EVENTS; k++)
               if (a == 8'(SYSREGS_ADR_CNT_BASE + k))
                  rdata = 32'(cnt[k]);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb.ack   <= 1'b0;
         wb.dat_o <= '0;
         scratch  <= '0;
         ctrl     <= '0;
         srst_cnt <= '0;
      end else begin
         wb.ack <= acc;
         if (rd)
            wb.dat_o <= rdata;
         if (wr && a == SYSREGS_ADR_SCRATCH)
            scratch <= wb.dat_i;
         if (wr && a == SYSREGS_ADR_CTRL) begin
            ctrl.led_en <= wb.dat_i[CTRL_LED_EN_BIT];
            ctrl.led    <= 16'(wb.dat_i[CTRL_LED_LSB +: LED_WIDTH]);
         end
         // Trigger bit is never stored; it only reloads the pulse counter.
         if (wr && a == SYSREGS_ADR_CTRL && wb.dat_i[CTRL_SRST_BIT])
            srst_cnt <= SRST_W'(SOFT_RST_CYCLES);
         else if (srst_cnt != '0)
            srst_cnt <= srst_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_system_regs.sv
// Directed bench for wb_system_regs with COUNTER_WIDTH=2, SOFT_RST_CYCLES=16, LED_WIDTH=6.
// Define SYSREGS_UPTIME_EN to exercise the coherent uptime pair instead of the zero reads.
module tb_wb_system_regs;

   localparam int NE  = 4;
   localparam int CW  = 2;
   localparam int SRC = 16;
   localparam int LW  = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NE-1:0] event_i = '0;
   logic [31:0]   status_i = '0;
   logic [LW-1:0] led_i = 6'h15;
   logic [LW-1:0] led_o;
   logic          soft_rst_o;
   logic [31:0]   d;
   logic [31:0]   lo;
   logic [31:0]   hi;
   int            n_chk = 0;
   int            n_err = 0;
   int            srst_hi = 0;
   int            base;

   wb_interface wb();

   wb_system_regs #(
      .DESIGN_ID(32'h0000_0001),
      .WB_FIFO_DEPTH(2048),
      .NUM_EVENTS(NE),
      .COUNTER_WIDTH(CW),
      .SOFT_RST_CYCLES(SRC),
      .LED_WIDTH(LW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wb(wb),
      .event_i(event_i),
      .status_i(status_i),
      .led_i(led_i),
      .led_o(led_o),
      .soft_rst_o(soft_rst_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (soft_rst_o) srst_hi++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [7:0] adr,
                       input logic [31:0] wd, input logic [NE-1:0] ev,
                       output logic [31:0] rdv);
      @(negedge clk);
      wb.adr = {24'h0, adr};
      wb.dat_i = wd;
      wb.we = w;
      wb.cyc = 1'b1;
      wb.stb = 1'b1;
      event_i = event_i | ev;
      @(posedge clk);
      @(negedge clk);
      chk("ack", 32'(wb.ack), 32'd1);
      rdv = wb.dat_o;
      wb.cyc = 1'b0;
      wb.stb = 1'b0;
      wb.we = 1'b0;
      event_i = event_i & ~ev;
   endtask

   task automatic wr(input logic [7:0] adr, input logic [31:0] wd);
      logic [31:0] x;
      xfer(1'b1, adr, wd, '0, x);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] adr,
                         input logic [31:0] exp);
      logic [31:0] x;
      xfer(1'b0, adr, 32'h0, '0, x);
      chk(tag, x, exp);
   endtask

   task automatic pulse(input int k);
      @(negedge clk);
      event_i[k] = 1'b1;
      @(negedge clk);
      event_i[k] = 1'b0;
   endtask

   task automatic wait_srst_low();
      for (int i = 0; i < 64; i++) begin
         if (!soft_rst_o) break;
         @(negedge clk);
      end
   endtask

   initial begin
      wb.adr = '0;
      wb.dat_i = '0;
      wb.we = 1'b0;
      wb.cyc = 1'b0;
      wb.stb = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(wb.ack), 32'd0);
      chk("rst_dat", wb.dat_o, 32'd0);
      chk("rst_srst", 32'(soft_rst_o), 32'd0);
      chk("rst_led", 32'(led_o), 32'h15);
      rst_n = 1'b1;

      // back-to-back read of the ID word: ack 0,1,0,1
      @(negedge clk);
      wb.adr = 32'h0;
      wb.we = 1'b0;
      wb.cyc = 1'b1;
      wb.stb = 1'b1;
      chk("ack_pre", 32'(wb.ack), 32'd0);
      @(negedge clk);
      chk("ack_1", 32'(wb.ack), 32'd1);
      chk("id", wb.dat_o, 32'h0000_0001);
      @(negedge clk);
      chk("ack_gap", 32'(wb.ack), 32'd0);
      @(negedge clk);
      chk("ack_2", 32'(wb.ack), 32'd1);
      wb.cyc = 1'b0;
      wb.stb = 1'b0;
      @(negedge clk);
      chk("ack_end", 32'(wb.ack), 32'd0);

      rd_chk("scratch_rst", 8'h02, 32'd0);
      rd_chk("fifo", 8'h01, 32'd2048);
      wr(8'h02, 32'hDEAD_BEEF);
      chk("dat_hold", wb.dat_o, 32'd2048);
      rd_chk("scratch", 8'h02, 32'hDEAD_BEEF);
      rd_chk("unmapped", 8'h7F, 32'd0);
      wr(8'h7F, 32'h1234_5678);
      rd_chk("cnt_oob", 8'h0C, 32'd0);
      status_i = 32'hA5C3_0F1E;
      rd_chk("status", 8'h07, 32'hA5C3_0F1E);

`ifdef SYSREGS_UPTIME_EN
      @(negedge clk);
      force dut.uptime = 64'h0000_0000_FFFF_FFFE;
      @(negedge clk);
      release dut.uptime;
      xfer(1'b0, 8'h03, 32'h0, '0, lo);
      xfer(1'b0, 8'h04, 32'h0, '0, hi);
      chk("uptime_pair",
          32'((hi == 32'd0 && lo >= 32'hFFFF_FFFE) ||
              (hi == 32'd1 && lo < 32'd16)), 32'd1);
`else
      xfer(1'b0, 8'h03, 32'h0, '0, lo);
      xfer(1'b0, 8'h04, 32'h0, '0, hi);
      chk("uptime_lo_off", lo, 32'd0);
      chk("uptime_hi_off", hi, 32'd0);
`endif

      repeat (3) pulse(1);
      rd_chk("cnt1_3", 8'h09, 32'd3);
      rd_chk("cnt0", 8'h08, 32'd0);
      pulse(1);
      rd_chk("cnt1_sat", 8'h09, 32'd3);
      rd_chk("flags", 8'h06, 32'h2);
      xfer(1'b1, 8'h06, 32'h2, 4'b0010, d);
      rd_chk("flag_set_wins", 8'h06, 32'h2);
      wr(8'h06, 32'h2);
      rd_chk("flag_w1c", 8'h06, 32'h0);
      wr(8'h09, 32'h0);
      rd_chk("cnt1_clr", 8'h09, 32'd0);
      xfer(1'b1, 8'h09, 32'h0, 4'b0010, d);
      rd_chk("cnt1_clr_inc", 8'h09, 32'd1);

      wr(8'h05, 32'h0000_2A02);
      chk("led_ovr", 32'(led_o), 32'h2A);
      rd_chk("ctrl", 8'h05, 32'h0000_2A02);
      wr(8'h05, 32'h0);
      chk("led_pass", 32'(led_o), 32'h15);
      led_i = 6'h0B;
      #1;
      chk("led_follow", 32'(led_o), 32'h0B);

      base = srst_hi;
      chk("srst_idle", 32'(soft_rst_o), 32'd0);
      wr(8'h05, 32'h1);
      chk("srst_start", 32'(soft_rst_o), 32'd1);
      wait_srst_low();
      chk("srst_len", 32'(srst_hi - base), 32'd16);
      rd_chk("ctrl_b0", 8'h05, 32'h0);

      base = srst_hi;
      wr(8'h05, 32'h1);
      repeat (8) @(negedge clk);
      wr(8'h05, 32'h1);
      wait_srst_low();
      chk("srst_retrig", 32'(srst_hi - base), 32'd26);

      wr(8'h05, 32'h1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("srst_rst", 32'(soft_rst_o), 32'd0);
      chk("ack_rst", 32'(wb.ack), 32'd0);
      rst_n = 1'b1;
      rd_chk("scratch_rst2", 8'h02, 32'd0);
      rd_chk("cnt1_rst", 8'h09, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
